// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from N_REQ requesters into a single UART
// transmitter, supervising each transfer with start and completion timeouts.
module uart_tx_arbiter #(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 1023,
  parameter int DONE_TIMEOUT  = 65535,
  localparam int ID_W         = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 uart_start,
  output logic [7:0]           uart_data,
  input  logic                 uart_ready,
  input  logic                 uart_busy,
  input  logic                 uart_error,
  output logic [ID_W-1:0]      grant_id,
  output logic                 arb_busy,
  output logic                 timeout_err,
  output logic [7:0]           err_count,
  output logic [1:0]           state_dbg
);

  // Handshake: requester k transfers when req_valid[k] && req_ready[k] at a rising
  // edge; req_ready is one-hot, combinational, and only ever raised in IDLE.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [15:0] START_LIMIT = 16'(START_TIMEOUT);
  localparam logic [15:0] DONE_LIMIT  = 16'(DONE_TIMEOUT);

  state_t          state;
  logic [15:0]     timer;
  logic [15:0]     timer_inc;
  logic [ID_W-1:0] last_grant;
  logic            err_seen;
  logic [7:0]      req_bytes [N_REQ];
  logic            pick_valid;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W-1:0] cand;
  logic            can_accept;
  logic            handshake;
  logic            err_now;

  for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Scan from the farthest offset down so the nearest valid requester after
  // last_grant wins; last_grant itself ranks lowest.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(last_grant) + i) % N_REQ);
      if (req_valid[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    can_accept = rst_n && (state == IDLE) && uart_ready && !uart_busy && pick_valid;
    req_ready  = '0;
    if (can_accept) req_ready[pick_idx] = 1'b1;
    handshake  = |(req_valid & req_ready);
    err_now    = uart_error && ((state == WAIT_BUSY) || (state == WAIT_DONE));
    timer_inc  = (timer == 16'hFFFF) ? timer : timer + 16'd1;
  end

  assign arb_busy  = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      last_grant  <= ID_W'(N_REQ - 1);
      grant_id    <= '0;
      uart_start  <= 1'b0;
      uart_data   <= '0;
      timeout_err <= 1'b0;
      err_count   <= '0;
      err_seen    <= 1'b0;
    end else begin
      uart_start  <= 1'b0;
      timeout_err <= 1'b0;
      if (err_now && !err_seen) begin
        err_seen <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
      case (state)
        IDLE: begin
          if (handshake) begin
            uart_data  <= req_bytes[pick_idx];
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            err_seen   <= 1'b0;
            uart_start <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (timer == START_LIMIT) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else if (uart_busy) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else begin
            timer <= timer_inc;
          end
        end
        WAIT_DONE: begin
          // A timeout in the same cycle as completion still reports the timeout.
          if (timer == DONE_LIMIT) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else if (!uart_busy && uart_ready) begin
            state <= IDLE;
          end else begin
            timer <= timer_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART model (busy two
// cycles after start, 20 cycles long) that can also hang or report errors.
module tb_uart_tx_arbiter;

  localparam int N_REQ = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_WBUSY = 2'd2, S_WDONE = 2'd3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_REQ-1:0]  req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]  req_ready;
  logic              uart_start;
  logic [7:0]        uart_data;
  logic              uart_ready = 1'b1;
  logic              uart_busy  = 1'b0;
  logic              uart_error = 1'b0;
  logic [1:0]        grant_id;
  logic              arb_busy;
  logic              timeout_err;
  logic [7:0]        err_count;
  logic [1:0]        state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  // UART model controls: 0 normal, 1 never goes busy, 2 stays busy.
  int m_mode = 0;
  int m_err_each = 0;
  int m_dly = 0;
  int m_len = 0;
  int m_err_left = 0;

  logic [7:0] byte_tab [N_REQ] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  logic [7:0] exp_q [$];

  uart_tx_arbiter #(
    .N_REQ(N_REQ),
    .START_TIMEOUT(15),
    .DONE_TIMEOUT(40)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .uart_start(uart_start),
    .uart_data(uart_data),
    .uart_ready(uart_ready),
    .uart_busy(uart_busy),
    .uart_error(uart_error),
    .grant_id(grant_id),
    .arb_busy(arb_busy),
    .timeout_err(timeout_err),
    .err_count(err_count),
    .state_dbg(state_dbg)
  );

  // Clock and UART model; the model updates on the falling edge.
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_dly = 0; m_len = 0; m_err_left = 0;
      uart_busy = 1'b0; uart_ready = 1'b1; uart_error = 1'b0;
    end else begin
      uart_error = 1'b0;
      if (uart_start === 1'b1) begin
        if (m_mode != 1) m_dly = 2;
        m_err_left = m_err_each;
      end else if (m_dly > 0) begin
        m_dly--;
        if (m_dly == 0) begin
          uart_busy = 1'b1;
          m_len = 20;
        end
      end else if (uart_busy) begin
        if (m_err_left > 0 && (m_len % 2) == 1) begin
          uart_error = 1'b1;
          m_err_left--;
        end
        if (m_mode != 2) begin
          m_len--;
          if (m_len == 0) uart_busy = 1'b0;
        end
      end
      uart_ready = !uart_busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    @(negedge clk);
    while (uart_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st);
    int n = 0;
    @(negedge clk);
    while (state_dbg !== st && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] exp_b;
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = {byte_tab[3], byte_tab[2], byte_tab[1], byte_tab[0]};
    step(3);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_start", uart_start, 0);
    check("rst_data", uart_data, 0);
    check("rst_ready", req_ready, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", arb_busy, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_errcnt", err_count, 0);

    // All four pending at reset release: served 0,1,2,3.
    for (int k = 0; k < N_REQ; k++) exp_q.push_back(byte_tab[k]);
    rst_n = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      wait_start("rr_start_seen");
      exp_b = exp_q.pop_front();
      check("rr_grant", grant_id, k);
      check("rr_data", uart_data, exp_b);
      check("rr_state_start", state_dbg, S_START);
      check("rr_ready_low", req_ready, 0);
      check("rr_arb_busy", arb_busy, 1);
      req_valid[k] = 1'b0;
      step(1);
      check("rr_start_one_cycle", uart_start, 0);
    end
    wait_state("rr_idle", S_IDLE);
    check("rr_arb_idle", arb_busy, 0);

    // Requester 2 held; requester 0 asserts once and must come next.
    req_valid = 4'b0100;
    wait_start("fair_s1");
    check("fair_g1", grant_id, 2);
    req_valid[0] = 1'b1;
    wait_start("fair_s2");
    check("fair_g2", grant_id, 0);
    check("fair_d2", uart_data, 8'hA0);
    req_valid[0] = 1'b0;
    wait_start("fair_s3");
    check("fair_g3", grant_id, 2);
    check("fair_d3", uart_data, 8'hC2);
    req_valid = '0;
    wait_state("fair_idle", S_IDLE);

    // UART never goes busy: timeout after 16 WAIT_BUSY cycles, then next grant.
    m_mode = 1;
    req_valid = 4'b1001;
    wait_start("stmo_start");
    check("stmo_grant", grant_id, 3);
    req_valid[3] = 1'b0;
    step(16);
    check("stmo_still_wait", state_dbg, S_WBUSY);
    check("stmo_not_yet", timeout_err, 0);
    step(1);
    check("stmo_pulse", timeout_err, 1);
    check("stmo_idle", state_dbg, S_IDLE);
    check("stmo_next_ready", req_ready, 4'b0001);
    m_mode = 0;
    step(1);
    check("stmo_pulse_end", timeout_err, 0);
    check("stmo_next_start", uart_start, 1);
    check("stmo_next_grant", grant_id, 0);
    req_valid = '0;
    wait_state("stmo_idle2", S_IDLE);

    // UART stays busy: completion timeout 44 cycles after the start cycle.
    m_mode = 2;
    req_valid = 4'b0010;
    wait_start("dtmo_start");
    check("dtmo_grant", grant_id, 1);
    req_valid = '0;
    n = 0;
    while (timeout_err !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("dtmo_latency", n, 44);
    check("dtmo_idle", state_dbg, S_IDLE);
    step(1);
    check("dtmo_pulse_end", timeout_err, 0);
    m_mode = 0;
    step(30);

    // Three error pulses in one transfer count once.
    m_err_each = 3;
    req_valid = 4'b0100;
    wait_start("err_start");
    check("err_grant", grant_id, 2);
    check("err_before", err_count, 0);
    req_valid = '0;
    wait_state("err_idle", S_IDLE);
    check("err_once", err_count, 1);

    // 299 more erroring transfers: count saturates at 255.
    m_err_each = 1;
    req_valid = 4'b0001;
    for (int i = 0; i < 299; i++) begin
      wait_start("sat_start");
      if (i == 10) check("sat_mid", err_count, 11);
      if (i == 254) check("sat_reach", err_count, 255);
      if (i == 260) check("sat_hold", err_count, 255);
    end
    req_valid = '0;
    wait_state("sat_idle", S_IDLE);
    check("sat_final", err_count, 255);
    m_err_each = 0;

    // Short request pulse while busy leaves no trace.
    req_valid = 4'b1000;
    wait_start("blip_start");
    check("blip_grant", grant_id, 3);
    req_valid = '0;
    wait_state("blip_wdone", S_WDONE);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("blip_no_ready", req_ready, 0);
    end
    req_valid[1] = 1'b0;
    wait_state("blip_idle", S_IDLE);
    step(5);
    check("blip_stay_idle", state_dbg, S_IDLE);
    check("blip_grant_kept", grant_id, 3);

    // Asynchronous reset in WAIT_DONE.
    req_valid = 4'b0010;
    wait_start("arst_start");
    check("arst_grant", grant_id, 1);
    req_valid = 4'b0110;
    wait_state("arst_wdone", S_WDONE);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state_dbg, S_IDLE);
    check("arst_data", uart_data, 0);
    check("arst_grant0", grant_id, 0);
    check("arst_busy", arb_busy, 0);
    check("arst_errcnt", err_count, 0);
    check("arst_tmo", timeout_err, 0);
    check("arst_start0", uart_start, 0);
    check("arst_ready", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("arst_hold_tmo", timeout_err, 0);
      check("arst_hold_ready", req_ready, 0);
    end
    rst_n = 1'b1;
    wait_start("arst_after_start");
    check("arst_after_grant", grant_id, 1);
    check("arst_after_data", uart_data, 8'hB1);
    req_valid = '0;
    wait_state("arst_after_idle", S_IDLE);
    check("arst_after_tmo", timeout_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
